// File: rtl/game_pkg.sv
// Shared game constants: coordinate width, ghost ids, collision FSM encoding,
// and the unsigned distance helper used by the catch comparators.
package game_pkg;

   localparam int COORD_W      = 9;
   localparam int HIT_DIST_DEF = 6;
   localparam int NUM_MON      = 3;

   localparam int MON_ID_1 = 0;
   localparam int MON_ID_2 = 1;
   localparam int MON_ID_3 = 2;

   localparam logic [1:0] ST_PLAY   = 2'd0;
   localparam logic [1:0] ST_FREEZE = 2'd1;
   localparam logic [1:0] ST_INVULN = 2'd2;
   localparam logic [1:0] ST_OVER   = 2'd3;

   typedef logic [COORD_W-1:0] coord_t;

   // Plain unsigned magnitude; screen coordinates never wrap around.
   function automatic coord_t abs_diff(input coord_t a, input coord_t b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/ghost_collision_ctrl_if.sv
// Positions and game-step controls in, lives/phase indications out.
interface ghost_collision_ctrl_if;
   import game_pkg::*;

   logic       tick;
   logic       restart;
   coord_t     p_x, p_y;
   coord_t     m1_x, m1_y, m2_x, m2_y, m3_x, m3_y;
   logic [2:0] lives;
   logic       hit;
   logic       freeze;
   logic       respawn;
   logic       invuln;
   logic       gameover;

   modport master (
      output tick, restart, p_x, p_y, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
      input  lives, hit, freeze, respawn, invuln, gameover
   );

   modport slave (
      input  tick, restart, p_x, p_y, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
      output lives, hit, freeze, respawn, invuln, gameover
   );

endinterface

// File: rtl/abs_diff_cmp.sv
// One axis of a catch test: high when |i_a - i_b| is strictly below i_limit.
module abs_diff_cmp
   import game_pkg::*;
(
   input  coord_t i_a,
   input  coord_t i_b,
   input  coord_t i_limit,
   output logic   o_lt
);

   assign o_lt = (abs_diff(i_a, i_b) < i_limit);

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Catch detection between pacman and three ghosts, plus the lives /
// freeze / respawn / invulnerability / game-over sequencing.
module ghost_collision_ctrl
   import game_pkg::*;
#(
   parameter int HIT_DIST     = HIT_DIST_DEF,
   parameter int LIVES_INIT   = 3,
   parameter int FREEZE_TICKS = 60,
   parameter int INVULN_TICKS = 120
)(
   input  logic                  clk_50mhz,
   input  logic                  rst,
   ghost_collision_ctrl_if.slave bus
);

   localparam int MAX_TICKS = (FREEZE_TICKS > INVULN_TICKS) ? FREEZE_TICKS : INVULN_TICKS;
   localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);

   localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_TICKS - 1);
   localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [2:0]       LIVES_RST   = 3'(LIVES_INIT);
   localparam coord_t           HIT_LIM     = coord_t'(HIT_DIST);

   coord_t               w_mx [NUM_MON];
   coord_t               w_my [NUM_MON];
   logic [NUM_MON-1:0]   w_near_x, w_near_y;
   logic                 w_coll;

   logic                 r_coll_q;
   logic [1:0]           r_state;
   logic [2:0]           r_lives;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_hit, r_respawn, r_freeze, r_invuln, r_gameover;

   logic [1:0]           w_state_nxt;
   logic [2:0]           w_lives_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_hit_nxt, w_respawn_nxt;

   assign w_mx[MON_ID_1] = bus.m1_x;
   assign w_my[MON_ID_1] = bus.m1_y;
   assign w_mx[MON_ID_2] = bus.m2_x;
   assign w_my[MON_ID_2] = bus.m2_y;
   assign w_mx[MON_ID_3] = bus.m3_x;
   assign w_my[MON_ID_3] = bus.m3_y;

   for (genvar k = 0; k < NUM_MON; k++) begin : g_mon
      abs_diff_cmp u_cmp_x (.i_a(bus.p_x), .i_b(w_mx[k]), .i_limit(HIT_LIM), .o_lt(w_near_x[k]));
      abs_diff_cmp u_cmp_y (.i_a(bus.p_y), .i_b(w_my[k]), .i_limit(HIT_LIM), .o_lt(w_near_y[k]));
   end

   // Any number of overlapping ghosts collapses into a single catch request.
   assign w_coll = |(w_near_x & w_near_y);

   // Next-state logic; restart overrides everything, including a pending catch.
   always_comb begin
      w_state_nxt   = r_state;
      w_lives_nxt   = r_lives;
      w_cnt_nxt     = r_cnt;
      w_hit_nxt     = 1'b0;
      w_respawn_nxt = 1'b0;
      if (bus.restart) begin
         w_state_nxt = ST_PLAY;
         w_lives_nxt = LIVES_RST;
         w_cnt_nxt   = CNT_ZERO;
      end else begin
         case (r_state)
            ST_PLAY: begin
               if (r_coll_q) begin
                  w_hit_nxt = 1'b1;
                  w_cnt_nxt = CNT_ZERO;
                  if (r_lives <= 3'd1) begin
                     w_lives_nxt = 3'd0;
                     w_state_nxt = ST_OVER;
                  end else begin
                     w_lives_nxt = r_lives - 3'd1;
                     w_state_nxt = ST_FREEZE;
                  end
               end else begin
                  w_state_nxt = ST_PLAY;
               end
            end
            ST_FREEZE: begin
               if (bus.tick) begin
                  if (r_cnt == FREEZE_LAST) begin
                     w_respawn_nxt = 1'b1;
                     w_cnt_nxt     = CNT_ZERO;
                     w_state_nxt   = ST_INVULN;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_ONE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end
            ST_INVULN: begin
               if (bus.tick) begin
                  if (r_cnt == INVULN_LAST) begin
                     w_cnt_nxt   = CNT_ZERO;
                     w_state_nxt = ST_PLAY;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_ONE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end
            ST_OVER: begin
               w_state_nxt = ST_OVER;
            end
            default: begin
               w_state_nxt = ST_PLAY;
               w_cnt_nxt   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counters and phase outputs; phase flags follow the next state so
   // freeze/invuln/gameover rise on the same edge as the pulse that causes them.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         r_coll_q   <= 1'b0;
         r_state    <= ST_PLAY;
         r_lives    <= LIVES_RST;
         r_cnt      <= CNT_ZERO;
         r_hit      <= 1'b0;
         r_respawn  <= 1'b0;
         r_freeze   <= 1'b0;
         r_invuln   <= 1'b0;
         r_gameover <= 1'b0;
      end else begin
         r_coll_q   <= w_coll;
         r_state    <= w_state_nxt;
         r_lives    <= w_lives_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hit      <= w_hit_nxt;
         r_respawn  <= w_respawn_nxt;
         r_freeze   <= (w_state_nxt == ST_FREEZE);
         r_invuln   <= (w_state_nxt == ST_INVULN);
         r_gameover <= (w_state_nxt == ST_OVER);
      end
   end

   assign bus.lives    = r_lives;
   assign bus.hit      = r_hit;
   assign bus.freeze   = r_freeze;
   assign bus.respawn  = r_respawn;
   assign bus.invuln   = r_invuln;
   assign bus.gameover = r_gameover;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Scenario bench for ghost_collision_ctrl; expected output words are queued
// when stimulus is applied and compared as the DUT cycles.
module tb_ghost_collision_ctrl;
   import game_pkg::*;

   localparam int FAR = 400;

   logic clk_50mhz = 1'b0;
   logic rst;
   always #10 clk_50mhz = ~clk_50mhz;

   ghost_collision_ctrl_if bus ();

   ghost_collision_ctrl #(
      .HIT_DIST(6), .LIVES_INIT(3), .FREEZE_TICKS(60), .INVULN_TICKS(120)
   ) dut (
      .clk_50mhz(clk_50mhz),
      .rst      (rst),
      .bus      (bus)
   );

   int         errors = 0;
   int         checks = 0;
   int         hits_seen = 0;
   int         resp_seen = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_v;

   // {lives[2:0], hit, freeze, respawn, invuln, gameover}
   wire [7:0] obs = {bus.lives, bus.hit, bus.freeze, bus.respawn, bus.invuln, bus.gameover};

   function automatic logic [7:0] pk(input int l, input logic h, input logic f,
                                     input logic r, input logic i, input logic g);
      logic [31:0] lv;
      lv = l;
      return {lv[2:0], h, f, r, i, g};
   endfunction

   task automatic step();
      @(posedge clk_50mhz);
      #1;
      if (bus.hit === 1'b1) hits_seen++;
      if (bus.respawn === 1'b1) resp_seen++;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         step();
      end
   endtask

   task automatic set_pos(input int px, input int py, input int x1, input int y1,
                          input int x2, input int y2, input int x3, input int y3);
      bus.p_x  = 9'(px); bus.p_y  = 9'(py);
      bus.m1_x = 9'(x1); bus.m1_y = 9'(y1);
      bus.m2_x = 9'(x2); bus.m2_y = 9'(y2);
      bus.m3_x = 9'(x3); bus.m3_y = 9'(y3);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.tick = 1'b0;
      bus.restart = 1'b0;
      set_pos(100, 100, FAR, FAR, 0, FAR, FAR, 0);
      #1 rst = 1'b1;
      #30;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_values: got %b want %b", obs, exp_v); end
      @(posedge clk_50mhz); #1 rst = 1'b0;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL reset_idle[%0d]: got %b want %b", c, obs, exp_v); end
      end
   endtask

   task automatic test_catch();
      set_pos(100, 100, 103, 97, 0, FAR, FAR, 0);
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      sb.push_back(pk(2, 0, 1, 0, 0, 0));
      for (int c = 0; c < 3; c++) begin
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL catch_seq[%0d]: got %b want %b", c, obs, exp_v); end
      end
   endtask

   task automatic test_freeze_respawn();
      int r0;
      r0 = resp_seen;
      ticks(59);
      sb.push_back(pk(2, 0, 1, 0, 0, 0));
      sb.push_back(pk(2, 0, 0, 1, 1, 0));
      sb.push_back(pk(2, 0, 0, 0, 1, 0));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL freeze_59: got %b want %b", obs, exp_v); end
      for (int c = 0; c < 2; c++) begin
         bus.tick = (c == 0) ? 1'b1 : 1'b0;
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL respawn_seq[%0d]: got %b want %b", c, obs, exp_v); end
      end
      bus.tick = 1'b0;
      checks++;
      if (resp_seen - r0 !== 1) begin errors++; $display("FAIL respawn_count: got %0d want 1", resp_seen - r0); end
   endtask

   task automatic test_invuln();
      int h0;
      h0 = hits_seen;
      ticks(119);
      sb.push_back(pk(2, 0, 0, 0, 1, 0));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL invuln_119: got %b want %b", obs, exp_v); end
      checks++;
      if (hits_seen !== h0) begin errors++; $display("FAIL invuln_no_hit: got %0d hits want 0", hits_seen - h0); end
      sb.push_back(pk(2, 0, 0, 0, 0, 0));
      sb.push_back(pk(1, 1, 1, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         bus.tick = (c == 0) ? 1'b1 : 1'b0;
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL invuln_exit[%0d]: got %b want %b", c, obs, exp_v); end
      end
      bus.tick = 1'b0;
   endtask

   task automatic test_gameover();
      int h0;
      set_pos(100, 100, FAR, FAR, 0, FAR, FAR, 0);
      ticks(180);
      sb.push_back(pk(1, 0, 0, 0, 0, 0));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL back_to_play: got %b want %b", obs, exp_v); end
      set_pos(100, 100, 103, 97, 0, FAR, FAR, 0);
      sb.push_back(pk(1, 0, 0, 0, 0, 0));
      sb.push_back(pk(0, 1, 0, 0, 0, 1));
      sb.push_back(pk(0, 0, 0, 0, 0, 1));
      for (int c = 0; c < 3; c++) begin
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL gameover_seq[%0d]: got %b want %b", c, obs, exp_v); end
      end
      h0 = hits_seen;
      ticks(5);
      sb.push_back(pk(0, 0, 0, 0, 0, 1));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || hits_seen !== h0) begin
         errors++; $display("FAIL over_ignores: got %b hits=%0d want %b hits=0", obs, hits_seen - h0, exp_v);
      end
      set_pos(100, 100, FAR, FAR, 0, FAR, FAR, 0);
      step();
      bus.restart = 1'b1;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         step();
         bus.restart = 1'b0;
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL restart_over[%0d]: got %b want %b", c, obs, exp_v); end
      end
   endtask

   task automatic test_restart_wins();
      int r0;
      r0 = resp_seen;
      set_pos(100, 100, FAR, FAR, 100, 100, FAR, 0);
      step();
      bus.restart = 1'b1;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         step();
         bus.restart = 1'b0;
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL restart_vs_coll[%0d]: got %b want %b", c, obs, exp_v); end
      end
      set_pos(100, 100, FAR, FAR, 0, FAR, FAR, 0);
      bus.restart = 1'b1;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      step();
      bus.restart = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || resp_seen !== r0) begin
         errors++; $display("FAIL restart_freeze: got %b resp=%0d want %b resp=0", obs, resp_seen - r0, exp_v);
      end
   endtask

   task automatic test_boundary();
      set_pos(0, 0, FAR, FAR, 6, 0, FAR, 0);
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      repeat (3) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL dx_6_no_hit: got %b want %b", obs, exp_v); end
      set_pos(0, 0, FAR, FAR, 5, 0, FAR, 0);
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      repeat (2) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL dx_5_hit: got %b want %b", obs, exp_v); end
      set_pos(300, 0, 2, 0, 0, FAR, FAR, 0);
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      repeat (3) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL no_wrap: got %b want %b", obs, exp_v); end
      set_pos(50, 50, FAR, FAR, 50, 44, FAR, 0);
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      repeat (3) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL dy_6_no_hit: got %b want %b", obs, exp_v); end
      set_pos(50, 50, FAR, FAR, 0, FAR, 45, 55);
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      repeat (2) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ghost3_diag_hit: got %b want %b", obs, exp_v); end
      set_pos(50, 50, FAR, FAR, 0, FAR, FAR, 0);
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
   endtask

   task automatic test_multi_and_reset_mid();
      int h0;
      h0 = hits_seen;
      set_pos(200, 200, 200, 200, 201, 199, 198, 202);
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      repeat (2) step();
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL multi_ghost: got %b want %b", obs, exp_v); end
      ticks(30);
      checks++;
      if (hits_seen - h0 !== 1 || obs !== pk(2, 0, 1, 0, 0, 0)) begin
         errors++; $display("FAIL multi_one_catch: hits=%0d obs=%b want hits=1", hits_seen - h0, obs);
      end
      #3 rst = 1'b1;
      #2;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %b want %b", obs, exp_v); end
      #2 rst = 1'b0;
      sb.push_back(pk(3, 0, 0, 0, 0, 0));
      sb.push_back(pk(2, 1, 1, 0, 0, 0));
      for (int c = 0; c < 2; c++) begin
         step();
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL post_reset_latency[%0d]: got %b want %b", c, obs, exp_v); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_catch();
      test_freeze_respawn();
      test_invuln();
      test_gameover();
      test_restart_wins();
      test_boundary();
      test_multi_and_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
